shot_responder: RTL
===================

// Module: shot_responder
// PURPOSE
//  Consumer end of the Start/Shot trigger interface. Samples the level-type Shot
//  output of the control FSM and detects its rising edges. Each accepted edge
//  fires a fixed burst of NUM_PULSES pulses on Fire, reported with Busy/Done.
//  Sits between the control block and the actuator/LED output stage.
// PARAMETERS
//  PULSE_WIDTH  4  Fire high time per pulse, in clk cycles (>=1)
//  PULSE_GAP    4  Fire low time between pulses, in clk cycles (>=1)
//  NUM_PULSES   3  pulses per burst (>=1)
//  CNT_W        8  width of timing counters; must hold max(PULSE_WIDTH,PULSE_GAP,NUM_PULSES)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  Shot        in   1  trigger level from control FSM (synchronous to clk)
//  Fire        out  1  burst output, registered
//  Busy        out  1  high while a burst is in progress (HIGH or LOW state)
//  Done        out  1  one-cycle pulse after the last pulse of a burst
//  Shot_count  out  8  accepted triggers, saturates at 8'hFF
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, Fire=0, Busy=0, Done=0, Shot_count=0,
//   shot_d=1.
//  Edge detect: shot_d <= Shot every cycle; edge = Shot & ~shot_d.
//   - shot_d resets to 1, so the one-cycle Shot=1 the control FSM emits right
//     after reset is NOT an edge. A Shot held high through reset release is
//     not an edge either.
//  FSM states: IDLE, HIGH, LOW, DONE. All outputs are registered.
//   IDLE: if edge -> HIGH; Fire<=1, Busy<=1, pulse_cnt<=1, tmr<=1,
//         Shot_count<=Shot_count+1 (hold at 8'hFF).
//   HIGH: if tmr==PULSE_WIDTH:
//           if pulse_cnt==NUM_PULSES -> DONE; Fire<=0, Busy<=0, Done<=1
//           else -> LOW; Fire<=0, tmr<=1
//         else tmr<=tmr+1.
//   LOW:  if tmr==PULSE_GAP -> HIGH; Fire<=1, tmr<=1, pulse_cnt<=pulse_cnt+1
//         else tmr<=tmr+1.
//   DONE: Done<=0 -> IDLE (Done is high for exactly 1 cycle).
//   Illegal state encoding -> IDLE with all outputs 0.
//  Latency: edge sampled at clk edge n -> Fire=1 from clk edge n+1.
//  Burst length = NUM_PULSES*PULSE_WIDTH + (NUM_PULSES-1)*PULSE_GAP cycles of
//   Busy, followed by 1 cycle of Done.
//  Edges while in HIGH, LOW or DONE are dropped. They are not queued and not
//   counted. shot_d still tracks Shot, so a Shot that stays high past DONE does
//   not retrigger.
//  Edge in the same cycle that IDLE is entered (DONE->IDLE) is dropped; an
//   edge sampled in IDLE is accepted.
//  Reset asserted mid-burst: Fire/Busy/Done drop immediately (async) and the
//   burst is abandoned.
// TESTING
//  T1 Reset release with Shot=1 for 1 cycle then 0 -> no Fire, Shot_count=0.
//  T2 Defaults, Shot 0->1 held 20 cycles -> Fire 4 high/4 low x3 (20 cycles
//     Busy), Done 1 cycle, Shot_count=1, no retrigger.
//  T3 Second Shot rising edge 5 cycles into a burst -> ignored, burst
//     unchanged, Shot_count stays 1.
//  T4 Shot toggled 0->1->0 with a 30-cycle period for 300 edges ->
//     Shot_count saturates at 8'hFF.
//  T5 reset=0 during the 2nd pulse -> Fire=0, Busy=0 asynchronously; after
//     release, a new edge gives a full 3-pulse burst.
//  T6 NUM_PULSES=1, PULSE_WIDTH=1 -> Fire high 1 cycle, Done on the next
//     cycle, Busy high 1 cycle.

Source files
------------

// File: rtl/shot_responder.sv
// Trigger consumer: detects rising edges of the level-type Shot input and fires a
// fixed burst of NUM_PULSES pulses on Fire, with Busy/Done status and a saturating trigger count.
module shot_responder #(
    parameter int PULSE_WIDTH = 4,
    parameter int PULSE_GAP   = 4,
    parameter int NUM_PULSES  = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Shot,
    output logic       Fire,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Shot_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_WIDTH = CNT_W'(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(PULSE_GAP);
    localparam logic [CNT_W-1:0] L_NUM   = CNT_W'(NUM_PULSES);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

    state_t           r_state;
    logic             r_shot_d;
    logic             r_fire;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic [7:0]       r_shot_count;

    state_t           w_state_nxt;
    logic             w_fire_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic [CNT_W-1:0] w_pulse_cnt_nxt;
    logic [7:0]       w_shot_count_nxt;
    logic             w_edge;

    // shot_d resets high so the post-reset Shot blip from the control FSM is not an edge.
    assign w_edge = Shot & ~r_shot_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shot_d     <= 1'b1;
            r_fire       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tmr        <= '0;
            r_pulse_cnt  <= '0;
            r_shot_count <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_shot_d     <= Shot;
            r_fire       <= w_fire_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_tmr        <= w_tmr_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
            r_shot_count <= w_shot_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fire_nxt       = r_fire;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_tmr_nxt        = r_tmr;
        w_pulse_cnt_nxt  = r_pulse_cnt;
        w_shot_count_nxt = r_shot_count;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt      = HIGH;
                    w_fire_nxt       = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_pulse_cnt_nxt  = L_ONE;
                    w_tmr_nxt        = L_ONE;
                    w_shot_count_nxt = (r_shot_count == 8'hFF) ? r_shot_count
                                                               : r_shot_count + 8'd1;
                end
            end
            HIGH: begin
                if (r_tmr == L_WIDTH) begin
                    w_fire_nxt = 1'b0;
                    if (r_pulse_cnt == L_NUM) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = LOW;
                        w_tmr_nxt   = L_ONE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + L_ONE;
                end
            end
            LOW: begin
                if (r_tmr == L_GAP) begin
                    w_state_nxt     = HIGH;
                    w_fire_nxt      = 1'b1;
                    w_tmr_nxt       = L_ONE;
                    w_pulse_cnt_nxt = r_pulse_cnt + L_ONE;
                end else begin
                    w_tmr_nxt = r_tmr + L_ONE;
                end
            end
            DONE: begin
                // Edges seen here are dropped; only an edge sampled in IDLE starts a burst.
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_fire_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign Fire       = r_fire;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Shot_count = r_shot_count;

endmodule
